// File: rtl/ifu_pc_fetch_if.sv
// ---------------------------------------------------------------------------
// ifu_pc_fetch_if
//
// Groups the signals of the IFU PC/fetch stage that do not carry clock or
// reset. The fetch stage connects through the "master" modport. The
// environment around it connects through the "slave" modport: the
// incrementer, the redirect source, instruction memory and decode.
//
// Signals (direction as seen from the fetch stage):
//   pc_cur         out 16  current fetch PC, fed to the incrementer
//   pc_inc         in  16  pc_cur + 1 from the combinational incrementer
//   redirect_valid in   1  branch/jump redirect this cycle
//   redirect_pc    in  16  redirect target
//   imem_req       out  1  fetch request valid
//   imem_addr      out 16  fetch address (always equals pc_cur)
//   imem_gnt       in   1  memory accepts the request this cycle
//   imem_rvalid    in   1  read data valid
//   imem_rdata     in  16  instruction word
//   inst_valid     out  1  queue head valid
//   inst_pc        out 16  PC of the queue head
//   inst_data      out 16  instruction at the queue head
//   inst_ready     in   1  decode consumes the head this cycle
// ---------------------------------------------------------------------------
interface ifu_pc_fetch_if;

  // Incrementer loop
  logic [15:0] pc_cur;
  logic [15:0] pc_inc;

  // Redirect from branch/jump resolution
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  // Instruction memory request/response
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [15:0] imem_rdata;

  // Decode side of the instruction queue
  logic        inst_valid;
  logic [15:0] inst_pc;
  logic [15:0] inst_data;
  logic        inst_ready;

  modport master (
    output pc_cur,
    input  pc_inc,
    input  redirect_valid,
    input  redirect_pc,
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output inst_valid,
    output inst_pc,
    output inst_data,
    input  inst_ready
  );

  modport slave (
    input  pc_cur,
    output pc_inc,
    output redirect_valid,
    output redirect_pc,
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  inst_valid,
    input  inst_pc,
    input  inst_data,
    output inst_ready
  );

endinterface : ifu_pc_fetch_if

// File: rtl/ifu_pc_fetch.sv
// ---------------------------------------------------------------------------
// ifu_pc_fetch
//
// Program-counter and fetch-control stage of the instruction fetch unit.
//   - Holds the fetch PC. It drives the PC to an external combinational
//     incrementer and takes back pc_inc in the same cycle.
//   - Sends requests to instruction memory one at a time. At most one
//     request is outstanding.
//   - Places returned instructions, tagged with their PC, in a 2-entry
//     queue for decode.
//   - A redirect loads the new PC and flushes the queue. If a response is
//     still in flight, the redirect marks it for dropping.
//
// Parameters:
//   RESET_PC   PC value loaded on reset
//   BUF_DEPTH  instruction queue depth (only 2 is supported)
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   ifu_pc_fetch_if.master (incrementer, redirect, imem, decode)
// ---------------------------------------------------------------------------
module ifu_pc_fetch #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  ifu_pc_fetch_if.master bus
);

  localparam logic [1:0] DEPTH = 2'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,   // no request; waiting for queue credit
    S_REQ  = 2'd1,   // imem_req high until granted
    S_WAIT = 2'd2    // one request outstanding, waiting for rvalid
  } state_t;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;            // architectural fetch PC
  logic [15:0] pend_pc_q, pend_pc_d;  // PC of the outstanding request
  logic        drop_q, drop_d;        // discard the next response

  // Queue storage plus its pointers and occupancy
  logic [15:0] q_pc   [BUF_DEPTH];
  logic [15:0] q_data [BUF_DEPTH];
  logic        rd_ptr_q, wr_ptr_q;
  logic [1:0]  count_q, count_d;

  logic        flush;
  logic        push;
  logic        pop;
  logic        has_room;

  // -------------------------------------------------------------------------
  // Queue control
  // -------------------------------------------------------------------------
  // A redirect overrides everything on the queue side. Any response that
  // arrives in the redirect cycle is thrown away, and so is any pop in that
  // cycle.
  assign flush = bus.redirect_valid;
  assign push  = (state_q == S_WAIT) && bus.imem_rvalid && !drop_q && !flush;
  assign pop   = (count_q != 2'd0) && bus.inst_ready && !flush;

  // NOTE: every variable written in this block gets a default first. A
  // path that skips an assignment would otherwise infer a latch.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // Credit is checked only at points where nothing will be outstanding
  // after this edge (IDLE, or WAIT while the response completes). Credit is
  // therefore just free space after this cycle's push/pop/flush. Using the
  // post-update occupancy lets a pop in IDLE start the next request at once.
  assign has_room = (count_d < DEPTH);

  // -------------------------------------------------------------------------
  // Fetch FSM: next state, PC and drop flag
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    drop_d    = drop_q;

    unique case (state_q)
      S_IDLE: begin
        // A flush empties the queue, so a redirect here always goes to REQ.
        if (has_room) state_d = S_REQ;
      end

      S_REQ: begin
        if (bus.imem_gnt) begin
          state_d   = S_WAIT;
          pend_pc_d = pc_q;
          pc_d      = bus.pc_inc;
          // Granted in the same cycle as a redirect: the response belongs
          // to the old path.
          if (flush) drop_d = 1'b1;
        end
        // Redirect without a grant: stay in REQ. The request re-issues at
        // redirect_pc.
      end

      S_WAIT: begin
        if (bus.imem_rvalid) begin
          // This response (delivered or dropped) ends the outstanding
          // request.
          drop_d  = 1'b0;
          state_d = has_room ? S_REQ : S_IDLE;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The redirect target wins over any incremented PC.
    if (flush) pc_d = bus.redirect_pc;
  end

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state is written only with non-blocking assignments.
  // Every flop then samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= 16'h0000;
      drop_q    <= 1'b0;
      count_q   <= 2'd0;
      rd_ptr_q  <= 1'b0;
      wr_ptr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      if (flush) begin
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        if (push) wr_ptr_q <= ~wr_ptr_q;
        if (pop)  rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Queue storage
  // -------------------------------------------------------------------------
  // NOTE: the entries are deliberately not reset. The head outputs are
  // forced to zero while the queue is empty, so stale contents are never
  // visible.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr_q]   <= pend_pc_q;
      q_data[wr_ptr_q] <= bus.imem_rdata;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign bus.pc_cur     = pc_q;
  assign bus.imem_addr  = pc_q;
  assign bus.imem_req   = (state_q == S_REQ);
  assign bus.inst_valid = (count_q != 2'd0);
  assign bus.inst_pc    = (count_q != 2'd0) ? q_pc[rd_ptr_q]   : 16'h0000;
  assign bus.inst_data  = (count_q != 2'd0) ? q_data[rd_ptr_q] : 16'h0000;

endmodule : ifu_pc_fetch
